ext_in_mailbox: RTL

//  Buffers words from an external producer and hands them one at a time to the pico core.

---
 rtl/ext_in_mailbox.sv | 98 +++++++++
 1 files changed

// File: rtl/ext_in_mailbox.sv
// Mailbox that queues producer words and hands them one at a time to the pico core as it waits for an interrupt.
// Latency: ext_data_o and ext_int_o update one cycle after wfi is seen in IDLE with data queued; a push into an empty FIFO takes 2 cycles.
// Backpressure: in_ready_o drops only while the FIFO is full; a pop in that cycle reopens it on the next cycle.
module ext_in_mailbox #(
    parameter int N     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N-1:0]             in_data_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [N-1:0]             ext_data_o,
    output logic                     ext_int_o,
    input  logic                     wfi_i,
    input  logic                     halt_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_WAKE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [N-1:0]    r_ext_data;
    logic            w_push;
    logic            w_pop;

    assign in_ready_o = (r_count != CW'(DEPTH));
    assign w_push     = in_valid_i && in_ready_o;
    assign count_o    = r_count;
    assign ext_data_o = r_ext_data;
    assign ext_int_o  = (r_state == S_PULSE);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wfi_i && !halt_i && (r_count != '0)) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_PULSE;
                end
            end
            S_PULSE: w_state_nxt = S_WAKE;
            // Returning to IDLE here means the earliest next pop is one cycle later,
            // so ext_int_o always has a low cycle between pulses.
            S_WAKE: begin
                if (!wfi_i || halt_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ext_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + AW'(1);
                r_ext_data <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy and pointers decide what is valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data_i;
        end
    end

endmodule
